// File: rtl/data_bus_apb_bridge.sv
// Load/store bridge from the RV32I data port to an APB completer.
// Sizes and aligns B/H/W accesses and runs SETUP/ACCESS with a wait-state
// timeout. It returns extended load data and stalls the core until done.
//
// state  | meaning
// IDLE   | waiting for a core request; sizes/aligns it on acceptance
// SETUP  | APB setup phase, PSEL=1 PENABLE=0 for one cycle
// ACCESS | APB access phase, waits for PREADY or the wait-state timeout
// RESP   | one-cycle done pulse back to the core, err as latched
module data_bus_apb_bridge #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWdata,
  output logic [31:0] dRdata,
  output logic        done,
  output logic        err,
  output logic        stall,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  output logic [3:0]  PSTRB,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  wait_cnt;
  logic [1:0]     addr_lo;
  logic [2:0]     funct3_q;
  logic           illegal;
  logic           resp_err;
  logic [3:0]     strb_new;
  logic [31:0]    wdata_new;
  logic [31:0]    load_val;
  logic [7:0]     byte_lane;
  logic [15:0]    half_lane;

  assign stall = req_valid & ~done;

  // Legality of the incoming request: misalignment, bad size, sized store.
  always_comb begin
    illegal = 1'b0;
    case (req_funct3)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = dAddr[0];
      3'b010:  illegal = |dAddr[1:0];
      3'b100:  illegal = req_we;
      3'b101:  illegal = req_we | dAddr[0];
      default: illegal = 1'b1;
    endcase
  end

  // Store lane placement: data replicated across lanes, strobes select one.
  always_comb begin
    strb_new  = 4'b0000;
    wdata_new = dWdata;
    if (req_we) begin
      case (req_funct3)
        3'b000: begin
          strb_new  = 4'b0001 << dAddr[1:0];
          wdata_new = {4{dWdata[7:0]}};
        end
        3'b001: begin
          strb_new  = 4'b0011 << {dAddr[1], 1'b0};
          wdata_new = {2{dWdata[15:0]}};
        end
        3'b010:  strb_new = 4'b1111;
        default: strb_new = 4'b0000;
      endcase
    end
  end

  // Load lane extraction and sign/zero extension from the live PRDATA.
  always_comb begin
    byte_lane = PRDATA[{addr_lo, 3'b000} +: 8];
    half_lane = PRDATA[{addr_lo[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_val = {{24{byte_lane[7]}}, byte_lane};
      3'b001:  load_val = {{16{half_lane[15]}}, half_lane};
      3'b100:  load_val = {24'd0, byte_lane};
      3'b101:  load_val = {16'd0, half_lane};
      default: load_val = PRDATA;
    endcase
  end

  // Next-state logic; resp_err is the error flag latched on entry to RESP.
  always_comb begin
    state_nxt = state;
    resp_err  = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && !done) begin
          state_nxt = illegal ? RESP : SETUP;
          resp_err  = illegal;
        end
      end
      SETUP: state_nxt = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          state_nxt = RESP;
          resp_err  = PSLVERR;
        end else if (wait_cnt == CW'(TIMEOUT)) begin
          state_nxt = RESP;
          resp_err  = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Wait-state counter: cleared entering SETUP, counts PREADY=0 access cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state_nxt == SETUP) begin
      wait_cnt <= '0;
    end else if (state == ACCESS && !PREADY && wait_cnt != CW'(TIMEOUT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Request capture; address/data/strobes then stay stable for the transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_lo  <= 2'b00;
      funct3_q <= 3'b000;
      PADDR    <= 32'd0;
      PWDATA   <= 32'd0;
      PSTRB    <= 4'b0000;
      PWRITE   <= 1'b0;
    end else if (state == IDLE && req_valid && !done) begin
      addr_lo  <= dAddr[1:0];
      funct3_q <= req_funct3;
      PADDR    <= {dAddr[31:2], 2'b00};
      PWDATA   <= wdata_new;
      PSTRB    <= strb_new;
      PWRITE   <= req_we;
    end
  end

  // APB select/enable and core response, all registered off the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      dRdata  <= 32'd0;
    end else begin
      PSEL    <= (state_nxt == SETUP) || (state_nxt == ACCESS);
      PENABLE <= (state_nxt == ACCESS);
      done    <= (state_nxt == RESP);
      err     <= (state_nxt == RESP) && resp_err;
      if (state_nxt == RESP) begin
        if (resp_err || state != ACCESS || PWRITE) dRdata <= 32'd0;
        else                                       dRdata <= load_val;
      end
    end
  end

endmodule
